// File: rtl/dmem_axi_master_if.sv
// AXI4-Lite bus bundle between the data-memory initiator and its responder.
interface dmem_axi_master_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic [AW-1:0]   AWADDR;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/dmem_axi_master.sv
// Single-outstanding AXI4-Lite initiator for the RV32I load/store unit.
// One core request becomes an AW/W/B or AR/R exchange; DONE pulses once per request.
module dmem_axi_master #(
    parameter int AXI_AWIDTH  = 10,
    parameter int AXI_DWIDTH  = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,
    input  logic                    MEM_REQ,
    input  logic                    MEM_WE,
    input  logic [31:0]             MEM_ADDR,
    input  logic [AXI_DWIDTH-1:0]   MEM_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] MEM_WSTRB,
    output logic [AXI_DWIDTH-1:0]   MEM_RDATA,
    output logic                    MEM_DONE,
    output logic                    MEM_ERR,
    output logic                    MEM_BUSY,
    dmem_axi_master_if.master       axi
);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_t;

    state_t                  state_q, state_d;
    logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DWIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [AXI_DWIDTH-1:0]   rdata_q, rdata_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                    arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
    logic                    done_q, done_d, err_q, err_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, hs_any, tmo;
    logic unused_addr;

    assign aw_hs  = awvalid_q & axi.AWREADY;
    assign w_hs   = wvalid_q & axi.WREADY;
    assign b_hs   = bready_q & axi.BVALID;
    assign ar_hs  = arvalid_q & axi.ARREADY;
    assign r_hs   = rready_q & axi.RVALID;
    assign hs_any = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    // Wait-state watchdog: fires on the edge where the count would reach TIMEOUT_CYC.
    assign tmo    = (TIMEOUT_CYC != 0) && (state_q != S_IDLE) && !hs_any &&
                    (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Byte-offset and high address bits carry no meaning on the word-addressed bus.
    assign unused_addr = ^{MEM_ADDR[31:AXI_AWIDTH+2], MEM_ADDR[1:0]};

    // Next-state, channel handshakes, completion and watchdog abort.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        aw_ok_d   = aw_ok_q;
        w_ok_d    = w_ok_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_d     = (state_q == S_IDLE || hs_any) ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (MEM_REQ) begin
                    addr_d  = MEM_ADDR[AXI_AWIDTH+1:2];
                    wdata_d = MEM_WDATA;
                    wstrb_d = MEM_WSTRB;
                    if (MEM_WE) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        aw_ok_d   = 1'b0;
                        w_ok_d    = 1'b0;
                    end else begin
                        state_d   = S_READ;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // AW and W retire independently; B may land with the last of them.
                awvalid_d = awvalid_q & ~aw_hs;
                wvalid_d  = wvalid_q & ~w_hs;
                aw_ok_d   = aw_ok_q | aw_hs;
                w_ok_d    = w_ok_q | w_hs;
                if (aw_ok_d && w_ok_d) begin
                    if (b_hs) begin
                        state_d  = S_IDLE;
                        bready_d = 1'b0;
                        done_d   = 1'b1;
                        err_d    = (axi.BRESP != 2'b00);
                    end else begin
                        state_d  = S_WRESP;
                        cnt_d    = '0;
                    end
                end
            end
            S_WRESP: begin
                if (b_hs) begin
                    state_d  = S_IDLE;
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = (axi.BRESP != 2'b00);
                end
            end
            S_READ: begin
                arvalid_d = arvalid_q & ~ar_hs;
                if (r_hs) begin
                    state_d  = S_IDLE;
                    rready_d = 1'b0;
                    rdata_d  = axi.RDATA;
                    done_d   = 1'b1;
                    err_d    = (axi.RRESP != 2'b00);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort leaves MEM_RDATA alone and reports an error completion.
        if (tmo) begin
            state_d   = S_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            cnt_d     = '0;
        end
    end

    // State and output registers; reset abandons any transaction without a DONE.
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            aw_ok_q   <= aw_ok_d;
            w_ok_q    <= w_ok_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign MEM_RDATA   = rdata_q;
    assign MEM_DONE    = done_q;
    assign MEM_ERR     = err_q;
    assign MEM_BUSY    = (state_q != S_IDLE);

    assign axi.AWADDR  = addr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARADDR  = addr_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;
endmodule

// File: tb/tb_dmem_axi_master.sv
// Bench for dmem_axi_master: delay-programmable AXI-Lite responder plus a
// word-level memory model, latency formula and per-request handshake counts.
module tb_dmem_axi_master;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        mem_done, mem_err, mem_busy;

    dmem_axi_master_if #(.AW(10), .DW(32)) axi ();

    dmem_axi_master #(.AXI_AWIDTH(10), .AXI_DWIDTH(32), .TIMEOUT_CYC(TMO)) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata), .MEM_WSTRB(mem_wstrb),
        .MEM_RDATA(mem_rdata), .MEM_DONE(mem_done), .MEM_ERR(mem_err), .MEM_BUSY(mem_busy),
        .axi(axi)
    );

    // responder configuration, set per request
    logic [7:0]  aw_dly = '0, w_dly = '0, b_dly = '0, ar_dly = '0, r_dly = '0;
    logic        ar_never = 1'b0;
    logic [1:0]  resp = '0;
    // responder state
    logic [7:0]  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, ar_got;
    logic [9:0]  aw_cap, ar_cap;
    logic [31:0] wd_cap;
    logic [3:0]  ws_cap;
    logic [31:0] mem [1024];

    assign axi.AWREADY = (aw_cnt >= aw_dly);
    assign axi.WREADY  = (w_cnt >= w_dly);
    assign axi.BVALID  = aw_got && w_got && (b_cnt >= b_dly);
    assign axi.BRESP   = resp;
    assign axi.ARREADY = !ar_never && (ar_cnt >= ar_dly);
    assign axi.RVALID  = ar_got && (r_cnt >= r_dly);
    assign axi.RDATA   = mem[ar_cap];
    assign axi.RRESP   = resp;

    // responder: ready after N valid cycles, B as a one-cycle pulse, commit on B
    always @(posedge clk) begin
        if (!rst_n) begin
            aw_cnt <= '0; w_cnt <= '0; b_cnt <= '0; ar_cnt <= '0; r_cnt <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_cap <= '0; ar_cap <= '0; wd_cap <= '0; ws_cap <= '0;
        end else begin
            if (axi.AWVALID && axi.AWREADY) begin
                aw_got <= 1'b1; aw_cap <= axi.AWADDR; aw_cnt <= '0;
            end else if (axi.AWVALID) aw_cnt <= aw_cnt + 8'd1;
            else aw_cnt <= '0;
            if (axi.WVALID && axi.WREADY) begin
                w_got <= 1'b1; wd_cap <= axi.WDATA; ws_cap <= axi.WSTRB; w_cnt <= '0;
            end else if (axi.WVALID) w_cnt <= w_cnt + 8'd1;
            else w_cnt <= '0;
            if (axi.BVALID) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= '0;
                for (int i = 0; i < 4; i++)
                    if (ws_cap[i]) mem[aw_cap][8*i +: 8] <= wd_cap[8*i +: 8];
            end else if (aw_got && w_got) b_cnt <= b_cnt + 8'd1;
            if (axi.ARVALID && axi.ARREADY) begin
                ar_got <= 1'b1; ar_cap <= axi.ARADDR; ar_cnt <= '0;
            end else if (axi.ARVALID) ar_cnt <= ar_cnt + 8'd1;
            else ar_cnt <= '0;
            if (axi.RVALID && axi.RREADY) begin
                ar_got <= 1'b0; r_cnt <= '0;
            end else if (ar_got && !axi.RVALID) r_cnt <= r_cnt + 8'd1;
        end
    end

    // handshake activity counters
    int n_done = 0, n_awv = 0, n_wv = 0, n_arv = 0;
    always @(posedge clk) begin
        if (mem_done)    n_done <= n_done + 1;
        if (axi.AWVALID) n_awv  <= n_awv + 1;
        if (axi.WVALID)  n_wv   <= n_wv + 1;
        if (axi.ARVALID) n_arv  <= n_arv + 1;
    end

    int n_chk = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: 16 words of memory and the last load result
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input int aw, input int wd, input int b, input int ar, input int r,
                       input logic [1:0] rs, input logic never);
        int lat, exp_lat, d0, aw0, w0, ar0;
        logic [3:0] w;
        w = addr[5:2];
        aw_dly = 8'(aw); w_dly = 8'(wd); b_dly = 8'(b); ar_dly = 8'(ar); r_dly = 8'(r);
        resp = rs; ar_never = never;
        d0 = n_done; aw0 = n_awv; w0 = n_wv; ar0 = n_arv;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = data; mem_wstrb = strb;
        @(posedge clk); #1;
        mem_req = 1'b0;
        if (we) begin
            chk({tag, ".awaddr"}, 32'(axi.AWADDR), 32'(w));
            chk({tag, ".wdata"}, axi.WDATA, data);
            chk({tag, ".wvld"}, 32'({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID}), 32'b1110);
        end else begin
            chk({tag, ".araddr"}, 32'(axi.ARADDR), 32'(w));
            chk({tag, ".rvld"}, 32'({axi.ARVALID, axi.RREADY, axi.AWVALID}), 32'b110);
        end
        lat = 1;
        while (!mem_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (never)   exp_lat = TMO + 1;
        else if (we) exp_lat = 3 + ((aw > wd) ? aw : wd) + b;
        else         exp_lat = 3 + ar + r;
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".err"}, 32'(mem_err), 32'(never || rs != 2'b00));
        if (!never) begin
            if (we) ref_mem[w] = merge(ref_mem[w], data, strb);
            else    exp_rdata = ref_mem[w];
        end
        chk({tag, ".rdata"}, mem_rdata, exp_rdata);
        @(posedge clk); #1;
        chk({tag, ".ndone"}, 32'(n_done - d0), 32'd1);
        if (we) begin
            chk({tag, ".awcyc"}, 32'(n_awv - aw0), 32'(aw + 1));
            chk({tag, ".wcyc"}, 32'(n_wv - w0), 32'(wd + 1));
        end else begin
            chk({tag, ".arcyc"}, 32'(n_arv - ar0), never ? 32'(TMO) : 32'(ar + 1));
        end
        chk({tag, ".idle"}, 32'({mem_busy, axi.AWVALID, axi.WVALID, axi.BREADY,
                                 axi.ARVALID, axi.RREADY}), 32'd0);
    endtask

    initial begin
        int d0;
        logic [31:0] tmp, a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ctl", 32'({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY,
                            mem_done, mem_err, mem_busy}), 32'd0);
        chk("rst.rdata", mem_rdata, 32'd0);
        chk("rst.bus", 32'({axi.AWADDR, axi.WSTRB}) | axi.WDATA, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // fill the modelled window so every later load has a known value
        for (int i = 0; i < 16; i++)
            txn("fill", 1'b1, 32'(i * 4), $urandom(), 4'hF, 0, 0, 0, 0, 0, 2'b00, 1'b0);

        txn("t1", 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 1'b0);
        txn("t2", 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0);
        chk("t2.cafe", mem_rdata, 32'hCAFEF00D);
        txn("t3", 1'b1, 32'h24, 32'h12345678, 4'h5, 2, 0, 0, 0, 0, 2'b00, 1'b0);
        txn("t4r", 1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b10, 1'b0);
        txn("t4w", 1'b1, 32'h28, 32'hA5A5A5A5, 4'hF, 0, 1, 0, 0, 0, 2'b00, 1'b0);
        txn("t5", 1'b0, 32'h28, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b1);
        chk("t5.keep", mem_rdata, exp_rdata);

        for (int n = 0; n < 40; n++) begin
            tmp = $urandom();
            a = {tmp[31:12], 6'b0, tmp[5:2], tmp[1:0]};
            txn("rnd", tmp[6], a, $urandom(), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'b0);
        end

        // reset while the write waits for a late B
        ar_never = 1'b0; resp = 2'b00; aw_dly = '0; w_dly = '0; b_dly = 8'd5;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1C; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(posedge clk); #1;
        chk("t6.busy", 32'(mem_busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        d0 = n_done;
        @(posedge clk); #1;
        chk("t6.ctl", 32'({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY,
                           mem_done, mem_err, mem_busy}), 32'd0);
        chk("t6.rdata", mem_rdata, 32'd0);
        exp_rdata = '0;
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        chk("t6.nodone", 32'(n_done - d0), 32'd0);
        txn("t6l", 1'b0, 32'h1C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 1'b0);
        txn("t6w", 1'b1, 32'h1C, 32'h0BADF00D, 4'hF, 1, 2, 1, 0, 0, 2'b00, 1'b0);
        txn("t6r", 1'b0, 32'h1C, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
